// File: rtl/blinkseq.sv
// blinkseq: LED pattern sequencer with three debounced buttons
// (faster / slower / run-pause toggle) and a power-of-two step-rate prescaler.
// Optional build macro: BLINKSEQ_PINGPONG_EN selects bounce-back sequencing
// (0,1,..,N-1,N-2,..,1,0,1,..) instead of wrap-around sequencing.
module blinkseq #(
  parameter int NLED   = 3,
  parameter int NSTEP  = 5,
  parameter int NSPEED = 4,
  parameter int PW     = 27,
  parameter int DBW    = 20,
  parameter logic [NSTEP*NLED-1:0] PATTERN =
    {3'b000, 3'b111, 3'b001, 3'b010, 3'b100}
) (
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic [2:0]                                       BTN,
  output logic [NLED-1:0]                                  LED,
  output logic [((NSPEED > 1) ? $clog2(NSPEED) : 1)-1:0]   SPEED,
  output logic                                             RUN
);

  localparam int SW  = (NSPEED > 1) ? $clog2(NSPEED) : 1;
  localparam int STW = $clog2(NSTEP);

  localparam logic [SW-1:0]  SPEED_MAX = SW'(NSPEED - 1);
  localparam logic [STW-1:0] STEP_LAST = STW'(NSTEP - 1);

  // Button bit positions
  localparam int BTN_FASTER = 0;
  localparam int BTN_SLOWER = 1;
  localparam int BTN_TOGGLE = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_t;

`ifdef BLINKSEQ_PINGPONG_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;
`endif

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-FF synchroniser, slow sample strobe, rising-edge
  // pulse. A button only becomes "armed" once it has been sampled released, so
  // a button held through reset release cannot fire until it is let go and
  // pressed again. Assumes DBW >= 2 so the first strobe after reset sees
  // synchronised button levels rather than the synchroniser reset value.
  // ---------------------------------------------------------------------------
  logic [2:0]     sync1_reg;
  logic [2:0]     sync2_reg;
  logic [DBW-1:0] dbcnt_reg;
  logic           strobe;
  logic [2:0]     samp_reg;
  logic [2:0]     samp_next;
  logic [2:0]     arm_reg;
  logic [2:0]     arm_next;
  logic [2:0]     pulse_reg;
  logic [2:0]     pulse_next;

  assign strobe = &dbcnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      // Per-button sample/arm/pulse next-state, evaluated only on the strobe
      assign samp_next[gi]  = strobe ? sync2_reg[gi] : samp_reg[gi];
      assign arm_next[gi]   = arm_reg[gi] | (strobe & ~sync2_reg[gi]);
      assign pulse_next[gi] = strobe & sync2_reg[gi] & ~samp_reg[gi] & arm_reg[gi];
    end
  endgenerate

  // Synchroniser, sample-period counter and debounce state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      dbcnt_reg <= '0;
      samp_reg  <= '0;
      arm_reg   <= '0;
      pulse_reg <= '0;
    end else begin
      sync1_reg <= BTN;
      sync2_reg <= sync1_reg;
      dbcnt_reg <= dbcnt_reg + 1'b1;
      samp_reg  <= samp_next;
      arm_reg   <= arm_next;
      pulse_reg <= pulse_next;
    end
  end

  logic faster_pulse;
  logic slower_pulse;
  logic toggle_pulse;

  assign faster_pulse = pulse_reg[BTN_FASTER];
  assign slower_pulse = pulse_reg[BTN_SLOWER];
  assign toggle_pulse = pulse_reg[BTN_TOGGLE];

  // ---------------------------------------------------------------------------
  // Sequencer core
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   pre_reg;
  logic [PW-1:0]   pre_next;
  logic [PW-1:0]   tick_mask;
  logic            tick;
  logic [SW-1:0]   speed_reg;
  logic [SW-1:0]   speed_next;
  logic [STW-1:0]  step_reg;
  logic [STW-1:0]  step_next;
  logic [NLED-1:0] led_reg;
  logic [NLED-1:0] led_next;
  run_state_t      run_state_reg;
  run_state_t      run_state_next;
  logic            advance;
`ifdef BLINKSEQ_PINGPONG_EN
  dir_t            dir_reg;
  dir_t            dir_next;
`endif

  // Step tick: the low (PW - SPEED) prescaler bits all ones; each speed level
  // halves the step period. Uses the registered speed, so a change applies
  // from the following cycle and the prescaler is never disturbed.
  always_comb begin
    pre_next  = pre_reg + 1'b1;
    tick_mask = {PW{1'b1}} >> speed_reg;
    tick      = ((pre_reg & tick_mask) == tick_mask);
  end

  // Speed index: saturating up/down; simultaneous opposite requests cancel
  always_comb begin
    speed_next = speed_reg;
    if (faster_pulse && !slower_pulse && (speed_reg != SPEED_MAX)) begin
      speed_next = speed_reg + 1'b1;
    end else if (slower_pulse && !faster_pulse && (speed_reg != '0)) begin
      speed_next = speed_reg - 1'b1;
    end
  end

  // Run/pause FSM: each toggle pulse flips between running and paused
  always_comb begin
    run_state_next = run_state_reg;
    case (run_state_reg)
      ST_RUN:   if (toggle_pulse) run_state_next = ST_PAUSE;
      ST_PAUSE: if (toggle_pulse) run_state_next = ST_RUN;
      default:  run_state_next = ST_RUN;
    endcase
  end

  // Step counter: advances on a tick while running (pre-toggle run state)
  always_comb begin
    step_next = step_reg;
    advance   = tick && (run_state_reg == ST_RUN);
`ifdef BLINKSEQ_PINGPONG_EN
    dir_next  = dir_reg;
    if (advance) begin
      if (dir_reg == DIR_UP) begin
        if (step_reg == STEP_LAST) begin
          step_next = step_reg - 1'b1;
          dir_next  = DIR_DOWN;
        end else begin
          step_next = step_reg + 1'b1;
        end
      end else begin
        if (step_reg == '0) begin
          step_next = STW'(1);
          dir_next  = DIR_UP;
        end else begin
          step_next = step_reg - 1'b1;
        end
      end
    end
`else
    if (advance) begin
      step_next = (step_reg == STEP_LAST) ? '0 : (step_reg + 1'b1);
    end
`endif
  end

  // LED pattern lookup for the current step; registered one cycle behind it
  always_comb begin
    led_next = PATTERN[int'(step_reg) * NLED +: NLED];
  end

  // Sequencer state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_reg       <= '0;
      speed_reg     <= '0;
      step_reg      <= '0;
      led_reg       <= PATTERN[NLED-1:0];
      run_state_reg <= ST_RUN;
    end else begin
      pre_reg       <= pre_next;
      speed_reg     <= speed_next;
      step_reg      <= step_next;
      led_reg       <= led_next;
      run_state_reg <= run_state_next;
    end
  end

`ifdef BLINKSEQ_PINGPONG_EN
  // Bounce direction register, starts counting up
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dir_reg <= DIR_UP;
    end else begin
      dir_reg <= dir_next;
    end
  end
`endif

  assign LED   = led_reg;
  assign SPEED = speed_reg;
  assign RUN   = (run_state_reg == ST_RUN);

endmodule

// File: tb/tb_blinkseq.sv
// tb_blinkseq: randomized + directed bench for blinkseq (PW=8, DBW=2) with a
// cycle-level behavioural model; honours BLINKSEQ_PINGPONG_EN when defined.
module tb_blinkseq;

  localparam int NLED   = 3;
  localparam int NSTEP  = 5;
  localparam int NSPEED = 4;
  localparam int PW     = 8;
  localparam int DBW    = 2;
`ifdef BLINKSEQ_PINGPONG_EN
  localparam int POS_PERIOD = 2 * NSTEP - 2;
`else
  localparam int POS_PERIOD = NSTEP;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] BTN = 3'b000;
  logic [2:0] LED;
  logic [1:0] SPEED;
  logic       RUN;

  blinkseq #(
    .NLED(NLED), .NSTEP(NSTEP), .NSPEED(NSPEED), .PW(PW), .DBW(DBW)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .LED(LED), .SPEED(SPEED), .RUN(RUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // LED value for each pattern step, written out from the pattern table
  logic [2:0] pat_tab [NSTEP] = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000};

  // Step shown for a given count of advances since reset
  function automatic int step_of(input int pos);
    int p;
    p = pos % POS_PERIOD;
`ifdef BLINKSEQ_PINGPONG_EN
    if (p >= NSTEP) p = POS_PERIOD - p;
`endif
    return p;
  endfunction

  // ---------------- behavioural model ----------------
  int       m_cnt, m_speed, m_pos, m_led_step, m_edges;
  bit       m_run;
  bit [2:0] m_prev1, m_prev2, m_last, m_armed, m_pend;
  bit       t_tick, t_run;
  int       t_speed, t_pos;
  bit [2:0] t_pend;

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      m_cnt = 0; m_speed = 0; m_pos = 0; m_led_step = 0; m_edges = 0;
      m_run = 1'b1; m_prev1 = 0; m_prev2 = 0; m_last = 0; m_armed = 0; m_pend = 0;
    end else begin
      t_tick  = (((m_cnt + 1) % (1 << (PW - m_speed))) == 0);
      t_speed = m_speed;
      if (m_pend[0] && !m_pend[1] && m_speed < NSPEED - 1) t_speed = m_speed + 1;
      else if (m_pend[1] && !m_pend[0] && m_speed > 0)     t_speed = m_speed - 1;
      t_run = m_pend[2] ? !m_run : m_run;
      t_pos = (t_tick && m_run) ? (m_pos + 1) % POS_PERIOD : m_pos;
      t_pend = 3'b000;
      if ((m_edges % (1 << DBW)) == (1 << DBW) - 1) begin
        for (int b = 0; b < 3; b++) begin
          t_pend[b] = m_prev2[b] && !m_last[b] && m_armed[b];
          if (!m_prev2[b]) m_armed[b] = 1'b1;
          m_last[b] = m_prev2[b];
        end
      end
      m_led_step = step_of(m_pos);
      m_pos = t_pos; m_speed = t_speed; m_run = t_run; m_pend = t_pend;
      m_prev2 = m_prev1; m_prev1 = BTN;
      m_edges = m_edges + 1;
      m_cnt = (m_cnt + 1) % (1 << PW);
    end
  end

  // Per-cycle compare of all outputs against the model
  initial forever begin
    @(negedge CLK);
    #1;
    if (cmp_en) begin
      checks++;
      if (LED !== pat_tab[m_led_step] || SPEED !== m_speed[1:0] || RUN !== m_run) begin
        errors++;
        $display("FAIL model_cmp cycle %0d got led=%b speed=%0d run=%b expected led=%b speed=%0d run=%b",
                 cyc, LED, SPEED, RUN, pat_tab[m_led_step], m_speed, m_run);
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_led_change(input int budget, output int t_chg, output logic [2:0] v);
    logic [2:0] cur;
    bit seen;
    cur = LED; seen = 1'b0; t_chg = cyc; v = cur;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (LED !== cur) begin seen = 1'b1; t_chg = cyc; v = LED; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL led_change got timeout expected change within %0d cycles", budget);
    end
  endtask

  task automatic wait_led_value(input logic [2:0] val, input int budget);
    bit seen;
    seen = (LED === val);
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (LED === val) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL led_wait got %b expected %b within %0d cycles", LED, val, budget);
    end
  endtask

  task automatic press(input int b, input int hold);
    @(negedge CLK);
    BTN[b] = 1'b1;
    repeat (hold) @(negedge CLK);
    BTN[b] = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  int         t_prev, t_now, bad;
  logic [2:0] v_now;
  int         exp30 [5];
  logic [2:0] r_btn;
  int         r_hold;
  bit         r_rst;

  initial begin
`ifdef BLINKSEQ_PINGPONG_EN
    exp30 = '{2, 1, 7, 0, 7};
`else
    exp30 = '{2, 1, 7, 0, 4};
`endif
    RST = 1'b0; BTN = 3'b000;
    repeat (3) @(negedge CLK);
    cmp_en = 1'b1;
    chk("reset_led", int'(LED), 4);
    chk("reset_speed", int'(SPEED), 0);
    chk("reset_run", int'(RUN), 1);
    RST = 1'b1;

    // Free-running sequence at speed 0
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_led_change(600, t_now, v_now);
      chk($sformatf("seq_led%0d", k), int'(v_now), exp30[k]);
      if (k > 0) chk($sformatf("seq_period%0d", k), t_now - t_prev, 256);
      t_prev = t_now;
    end

    // Faster presses and the resulting step periods
    for (int s = 1; s <= 3; s++) begin
      press(0, 20);
      chk($sformatf("faster_speed%0d", s), int'(SPEED), s);
      wait_led_change(600, t_prev, v_now);
      wait_led_change(600, t_now, v_now);
      chk($sformatf("faster_period%0d", s), t_now - t_prev, 256 >> s);
    end
    press(0, 20);
    chk("faster_sat4", int'(SPEED), 3);
    press(0, 20);
    chk("faster_sat5", int'(SPEED), 3);

    // Simultaneous faster+slower cancels
    @(negedge CLK); BTN = 3'b011;
    repeat (20) @(negedge CLK); BTN = 3'b000;
    repeat (12) @(negedge CLK);
    chk("both_speed", int'(SPEED), 3);

    // Slower down to 0, then saturate
    for (int s = 2; s >= 0; s--) begin
      press(1, 20);
      chk($sformatf("slower_speed%0d", s), int'(SPEED), s);
    end
    press(1, 20);
    chk("slower_sat0", int'(SPEED), 0);

    // Pause at step 2 (reached going up), hold, resume
    wait_led_value(3'b010, 3000);
    wait_led_value(3'b001, 600);
    press(2, 20);
    chk("pause_run", int'(RUN), 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (LED !== 3'b001) bad++;
    end
    chk("pause_hold_badcycles", bad, 0);
    press(2, 20);
    chk("resume_run", int'(RUN), 1);
    wait_led_change(600, t_now, v_now);
    chk("resume_next_led", int'(v_now), 7);

    // Reset at step 3 with faster held through it
    press(0, 20);
    chk("pre_reset_speed", int'(SPEED), 1);
    wait_led_value(3'b111, 3000);
    @(negedge CLK); BTN[0] = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("async_reset_led", int'(LED), 4);
    chk("async_reset_speed", int'(SPEED), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (60) @(negedge CLK);
    chk("held_through_reset_speed", int'(SPEED), 0);
    BTN[0] = 1'b0;
    repeat (12) @(negedge CLK);
    press(0, 20);
    chk("repress_speed", int'(SPEED), 1);

    // Randomized button traffic with occasional resets
    for (int t = 0; t < 80; t++) begin
      r_btn  = 3'($urandom_range(0, 7));
      r_hold = $urandom_range(1, 40);
      r_rst  = ($urandom_range(0, 14) == 0);
      @(negedge CLK);
      if (r_rst) RST = 1'b0;
      BTN = r_btn;
      repeat (r_hold) @(negedge CLK);
      RST = 1'b1;
      $display("txn %0d btn=%b hold=%0d rst=%0d led=%b speed=%0d run=%0d",
               t, r_btn, r_hold, r_rst, LED, SPEED, RUN);
    end
    BTN = 3'b000;
    repeat (20) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
